// File: rtl/johnson_pkg.sv
// rtl/johnson_pkg.sv - shared constants and helpers for the Johnson decoder
package johnson_pkg;

    // FSM state encoding
    localparam logic [1:0] ST_SEARCH  = 2'd0;
    localparam logic [1:0] ST_ACQUIRE = 2'd1;
    localparam logic [1:0] ST_LOCKED  = 2'd2;

    // Default configuration
    localparam int DEF_N           = 4;
    localparam int DEF_LOCK_THRESH = 2;

    // Width of the consecutive-successor run counter (LOCK_THRESH is at most 15)
    localparam int RUN_W = 4;

    // Next index in a 2N-long Johnson sequence; the last index wraps to 0
    function automatic int unsigned next_index(input int unsigned idx,
                                               input int unsigned seq_len);
        return (idx + 1 >= seq_len) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/johnson_code_check.sv
// rtl/johnson_code_check.sv - combinational Johnson code legality check and index decode
module johnson_code_check #(
    parameter int N     = 4,
    parameter int IDX_W = 3
) (
    input  logic [N-1:0]     code_i,
    output logic             legal_o,
    output logic [IDX_W-1:0] index_o
);

    logic [N-1:0]   mag;
    logic [IDX_W:0] ones;
    logic [IDX_W:0] idx_full;

    // Fold the MSB=1 half onto the MSB=0 half: both are legal exactly when
    // the folded word is a run of ones starting at bit 0.
    always_comb begin
        ones = '0;
        for (int b = 0; b < N; b++) begin
            ones = ones + (IDX_W+1)'(code_i[b]);
        end
        mag      = code_i[N-1] ? ~code_i : code_i;
        legal_o  = ((mag & (mag + N'(1))) == '0);
        idx_full = code_i[N-1] ? ((IDX_W+1)'(2 * N) - ones) : ones;
        index_o  = idx_full[IDX_W-1:0];
    end

endmodule

// File: rtl/johnson_decoder.sv
// rtl/johnson_decoder.sv - Johnson code decoder with continuity check and lock FSM (option: JOHNSON_DEC_AUTOCORRECT_EN)
module johnson_decoder
    import johnson_pkg::*;
#(
    parameter int N           = DEF_N,
    parameter int IDX_W       = 3,
    parameter int LOCK_THRESH = DEF_LOCK_THRESH,
    parameter int ERR_W       = 8
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [N-1:0]     Code_in,
    input  logic             Code_valid,
    output logic [IDX_W-1:0] Index_out,
    output logic             Index_valid,
    output logic             Illegal,
    output logic             Seq_err,
    output logic             Locked,
    output logic [ERR_W-1:0] Err_count
);

    logic             code_legal;
    logic [IDX_W-1:0] code_idx;
    logic [IDX_W-1:0] succ_idx;
    logic             is_succ;

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic             iv_q, iv_d;
    logic             ill_q, ill_d;
    logic             se_q, se_d;
    logic             err_inc;
`ifdef JOHNSON_DEC_AUTOCORRECT_EN
    logic             bad_q, bad_d;
`endif

    johnson_code_check #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_check (
        .code_i  (Code_in),
        .legal_o (code_legal),
        .index_o (code_idx)
    );

    // idx_q doubles as prev_idx: every accepted code becomes the new reference
    assign succ_idx = IDX_W'(next_index(32'(idx_q), 32'(2 * N)));
    assign is_succ  = (code_idx == succ_idx);

    // Lock FSM, index tracking and error-event classification
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        run_d   = run_q;
        iv_d    = 1'b0;
        ill_d   = 1'b0;
        se_d    = 1'b0;
        err_inc = 1'b0;
`ifdef JOHNSON_DEC_AUTOCORRECT_EN
        bad_d   = bad_q;
`endif
        if (Code_valid) begin
            if (code_legal) begin
                idx_d = code_idx;
                iv_d  = 1'b1;
`ifdef JOHNSON_DEC_AUTOCORRECT_EN
                bad_d = 1'b0;
`endif
                case (state_q)
                    ST_SEARCH: begin
                        state_d = ST_ACQUIRE;
                        run_d   = '0;
                    end
                    ST_ACQUIRE: begin
                        if (!is_succ) begin
                            se_d  = 1'b1;
                            run_d = '0;
                        end else if (run_q == RUN_W'(LOCK_THRESH - 1)) begin
                            state_d = ST_LOCKED;
                            run_d   = '0;
                        end else begin
                            run_d = run_q + RUN_W'(1);
                        end
                    end
                    ST_LOCKED: begin
                        if (!is_succ) begin
                            se_d    = 1'b1;
                            err_inc = 1'b1;
                            state_d = ST_ACQUIRE;
                            run_d   = '0;
                        end
                    end
                    default: begin
                        state_d = ST_SEARCH;
                        run_d   = '0;
                    end
                endcase
            end else begin
                ill_d = 1'b1;
                case (state_q)
                    ST_SEARCH: ;
                    ST_LOCKED: begin
                        err_inc = 1'b1;
`ifdef JOHNSON_DEC_AUTOCORRECT_EN
                        // A single bad word is bridged by predicting the
                        // successor; a second one in a row drops lock.
                        if (bad_q) begin
                            state_d = ST_SEARCH;
                            run_d   = '0;
                            bad_d   = 1'b0;
                        end else begin
                            idx_d = succ_idx;
                            iv_d  = 1'b1;
                            bad_d = 1'b1;
                        end
`else
                        state_d = ST_SEARCH;
                        run_d   = '0;
`endif
                    end
                    default: begin
                        state_d = ST_SEARCH;
                        run_d   = '0;
                    end
                endcase
            end
        end
        err_d = (err_inc && (err_q != '1)) ? err_q + ERR_W'(1) : err_q;
    end

    // State and output registers; reset wins over a same-cycle valid code
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= ST_SEARCH;
            idx_q   <= '0;
            run_q   <= '0;
            err_q   <= '0;
            iv_q    <= 1'b0;
            ill_q   <= 1'b0;
            se_q    <= 1'b0;
`ifdef JOHNSON_DEC_AUTOCORRECT_EN
            bad_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            run_q   <= run_d;
            err_q   <= err_d;
            iv_q    <= iv_d;
            ill_q   <= ill_d;
            se_q    <= se_d;
`ifdef JOHNSON_DEC_AUTOCORRECT_EN
            bad_q   <= bad_d;
`endif
        end
    end

    assign Index_out   = idx_q;
    assign Index_valid = iv_q;
    assign Illegal     = ill_q;
    assign Seq_err     = se_q;
    assign Locked      = (state_q == ST_LOCKED);
    assign Err_count   = err_q;

endmodule

// File: tb/tb_johnson_decoder.sv
// tb/tb_johnson_decoder.sv - directed self-checking bench for johnson_decoder
module tb_johnson_decoder;

    logic       Clock = 1'b0;
    logic       Reset;
    logic [3:0] Code_in;
    logic       Code_valid;
    logic [2:0] Index_out;
    logic       Index_valid;
    logic       Illegal;
    logic       Seq_err;
    logic       Locked;
    logic [7:0] Err_count;

    int errors = 0;
    int checks = 0;
    int ec_b;
    int e;
    int cur;
    int a;

    johnson_decoder #(
        .N           (4),
        .IDX_W       (3),
        .LOCK_THRESH (2),
        .ERR_W       (8)
    ) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .Code_in     (Code_in),
        .Code_valid  (Code_valid),
        .Index_out   (Index_out),
        .Index_valid (Index_valid),
        .Illegal     (Illegal),
        .Seq_err     (Seq_err),
        .Locked      (Locked),
        .Err_count   (Err_count)
    );

    always #5 Clock = ~Clock;

    // Johnson pattern for an index of the N=4 sequence
    function automatic logic [3:0] jc(input int i);
        logic [3:0] r;
        r = '0;
        if (i < 4) begin
            for (int b = 0; b < i; b++) r[b] = 1'b1;
        end else begin
            for (int b = 0; b < 8 - i; b++) r[3-b] = 1'b1;
        end
        return r;
    endfunction

    // {Index_out, Index_valid, Illegal, Seq_err, Locked, Err_count}
    function automatic logic [14:0] pk(input int idx, input int iv, input int ill,
                                       input int se, input int lk, input int ec);
        return {3'(idx), 1'(iv), 1'(ill), 1'(se), 1'(lk), 8'(ec)};
    endfunction

    task automatic step(input logic [3:0] c, input logic v);
        @(negedge Clock);
        Code_in    = c;
        Code_valid = v;
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [14:0] exp);
        logic [14:0] obs;
        obs = {Index_out, Index_valid, Illegal, Seq_err, Locked, Err_count};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        Reset = 1'b1; Code_in = '0; Code_valid = 1'b0;
        step(4'b0000, 1'b0);
        step(4'b0001, 1'b1);
        chk("reset_state", pk(0, 0, 0, 0, 0, 0));
        Reset = 1'b0;

        // acquisition and lock
        step(4'b0000, 1'b1); chk("acq_0", pk(0, 1, 0, 0, 0, 0));
        step(4'b0001, 1'b1); chk("acq_1", pk(1, 1, 0, 0, 0, 0));
        step(4'b0011, 1'b1); chk("lock_2", pk(2, 1, 0, 0, 1, 0));
        step(4'b0111, 1'b1); chk("lock_3", pk(3, 1, 0, 0, 1, 0));
        step(4'b0000, 1'b0); chk("gap_hold", pk(3, 0, 0, 0, 1, 0));
        step(4'b1111, 1'b1); chk("idx_4", pk(4, 1, 0, 0, 1, 0));
        step(4'b1110, 1'b1); chk("idx_5", pk(5, 1, 0, 0, 1, 0));
        step(4'b1100, 1'b1); chk("idx_6", pk(6, 1, 0, 0, 1, 0));
        step(4'b1000, 1'b1); chk("idx_7", pk(7, 1, 0, 0, 1, 0));
        step(4'b0000, 1'b1); chk("wrap_0", pk(0, 1, 0, 0, 1, 0));
        step(4'b0001, 1'b1); chk("idx_1", pk(1, 1, 0, 0, 1, 0));
        step(4'b0011, 1'b1); chk("idx_2", pk(2, 1, 0, 0, 1, 0));
        step(4'b0111, 1'b1); chk("idx_3b", pk(3, 1, 0, 0, 1, 0));

        // illegal code while locked, then a second one
`ifdef JOHNSON_DEC_AUTOCORRECT_EN
        step(4'b0101, 1'b1); chk("ill_locked", pk(4, 1, 1, 0, 1, 1));
        step(4'b0101, 1'b1); chk("ill_twice", pk(4, 0, 1, 0, 0, 2));
        ec_b = 2;
`else
        step(4'b0101, 1'b1); chk("ill_locked", pk(3, 0, 1, 0, 0, 1));
        step(4'b0101, 1'b1); chk("ill_search", pk(3, 0, 1, 0, 0, 1));
        ec_b = 1;
`endif

        // relock, then a non-successor while locked, relock across a gap
        step(4'b0000, 1'b1); chk("re_acq_0", pk(0, 1, 0, 0, 0, ec_b));
        step(4'b0001, 1'b1); chk("re_acq_1", pk(1, 1, 0, 0, 0, ec_b));
        step(4'b0011, 1'b1); chk("re_lock", pk(2, 1, 0, 0, 1, ec_b));
        step(4'b1110, 1'b1); chk("seq_err_locked", pk(5, 1, 0, 1, 0, ec_b + 1));
        step(4'b1100, 1'b1); chk("acq_6", pk(6, 1, 0, 0, 0, ec_b + 1));
        step(4'b0110, 1'b0); chk("acq_gap", pk(6, 0, 0, 0, 0, ec_b + 1));
        step(4'b1000, 1'b1); chk("relock_7", pk(7, 1, 0, 0, 1, ec_b + 1));

        // repeated code is a sequence error
        step(4'b1000, 1'b1); chk("repeat_code", pk(7, 1, 0, 1, 0, ec_b + 2));
        step(4'b0000, 1'b1); chk("rep_acq_0", pk(0, 1, 0, 0, 0, ec_b + 2));
        step(4'b0001, 1'b1); chk("rep_lock_1", pk(1, 1, 0, 0, 1, ec_b + 2));
        step(4'b0000, 1'b1); chk("backstep", pk(0, 1, 0, 1, 0, ec_b + 3));
        step(4'b1010, 1'b1); chk("ill_acquire", pk(0, 0, 1, 0, 0, ec_b + 3));
        step(4'b0010, 1'b1); chk("ill_search2", pk(0, 0, 1, 0, 0, ec_b + 3));

        // saturating error counter
        step(4'b0000, 1'b1);
        step(4'b0001, 1'b1);
        step(4'b0011, 1'b1); chk("sat_lock", pk(2, 1, 0, 0, 1, ec_b + 3));
        cur = 2;
        e = ec_b + 3;
        for (int n = 0; n < 300; n++) begin
            a = (cur + 3) % 8;
            step(jc(a), 1'b1);
            e = (e < 255) ? e + 1 : 255;
            chk("sat_err", pk(a, 1, 0, 1, 0, e));
            step(jc((a + 1) % 8), 1'b1);
            step(jc((a + 2) % 8), 1'b1);
            cur = (a + 2) % 8;
        end
        chk("sat_final", pk(cur, 1, 0, 0, 1, 255));

        // reset beats a same-cycle valid code and discards history
        Reset = 1'b1;
        step(4'b0001, 1'b1); chk("reset_mid", pk(0, 0, 0, 0, 0, 0));
        Reset = 1'b0;
        step(4'b0001, 1'b1); chk("post_reset_1", pk(1, 1, 0, 0, 0, 0));
        step(4'b0011, 1'b1); chk("post_reset_2", pk(2, 1, 0, 0, 0, 0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
